// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. It issues sequential word reads to an instruction
//   ROM that has a 1-cycle registered read, and buffers each returned word with
//   its PC in a small prefetch FIFO. The FIFO head is offered to the core over
//   a valid/ready handshake. A redirect flushes the FIFO, kills any in-flight
//   read and restarts fetching at the target. A misaligned target sets a
//   sticky error and halts issuing until reset.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active low
//   rom_req      out  ROM read enable for this cycle
//   rom_addr     out  ROM byte address (word aligned), 0 when rom_req=0
//   rom_data     in   ROM word, valid the cycle after rom_req
//   instr_valid  out  head entry holds a fetched instruction
//   instr_ready  in   core consumes the head entry this cycle
//   instr        out  head instruction word
//   instr_pc     out  PC of the head instruction
//   redirect     in   flush and restart fetch at redirect_pc
//   redirect_pc  in   redirect target
//   fetch_error  out  sticky: misaligned redirect target seen
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_error
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_inflight_pc;
  logic             r_inflight;
  logic             r_error;

  logic [31:0]      r_mem_data [DEPTH];
  logic [31:0]      r_mem_pc   [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_misaligned;
  logic [CNT_W-1:0] w_pending;

  assign w_misaligned = redirect && (redirect_pc[1:0] != 2'b00);

  // Buffered entries plus the read still in flight. Pops in the current cycle
  // are deliberately not credited, so a full FIFO can never overflow.
  assign w_pending = r_count + {{(CNT_W-1){1'b0}}, r_inflight};

  // A redirect kills the response arriving this cycle.
  assign w_push = r_inflight && !redirect;
  assign w_pop  = instr_valid && instr_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state. HALT is only left through reset.
  always_comb begin
    w_state_next = r_state;
    if (w_misaligned) begin
      w_state_next = S_HALT;
    end
  end

  // FSM: outputs (issue decision)
  always_comb begin
    w_issue = 1'b0;
    if ((r_state == S_RUN) && !redirect && (w_pending < CNT_W'(DEPTH))) begin
      w_issue = 1'b1;
    end
  end

  // The registers already hold their reset values while reset is low; gating
  // the request with reset only keeps the ROM port quiet during reset.
  assign rom_req  = w_issue && reset;
  assign rom_addr = rom_req ? r_fetch_pc : 32'h0000_0000;

  // ---------------------------------------------------------------------------
  // Fetch address, in-flight tracking and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0000_0000;
      r_error       <= 1'b0;
    end else begin
      if (redirect) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;   // wraps naturally at 2^32
      end
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_misaligned) begin
        r_error <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO control. A pop coinciding with a redirect still completes;
  // the flush simply empties whatever remains.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: data path only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= rom_data;
      r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

  // Head is read combinationally; forced to zero when empty so the outputs
  // never expose uninitialised storage.
  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_mem_data[r_rd_ptr] : 32'h0000_0000;
  assign instr_pc    = instr_valid ? r_mem_pc[r_rd_ptr]   : 32'h0000_0000;
  assign fetch_error = r_error;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural model keeps a queue of
//   issued fetches (PC and the cycle each becomes visible) and predicts the
//   request, valid and head outputs each cycle from the fetch rules. Directed
//   segments cover reset, streaming, backpressure, redirect, wrap, misaligned
//   target and asynchronous reset; a randomized phase mixes ready and redirect.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ROM_KEY  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_error;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_error (fetch_error)
  );

  // ROM with one-cycle registered read: word at A is A ^ ROM_KEY.
  always @(posedge clk) rom_data <= rom_addr ^ ROM_KEY;

  typedef struct {
    logic [31:0] pc;
    int          arrive;
  } ent_t;

  ent_t        q[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_fetch = RESET_PC;
  bit          halted_m = 1'b0;
  bit          err_m = 1'b0;
  logic        rst_val = 1'b0;
  int          cyc = 0;
  int          req_pulses = 0;
  int          first_req = -1;
  int          first_valid = -1;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, let them settle,
  // compare outputs against the model, then advance the model.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
    int   avail;
    logic exp_req;
    @(negedge clk);
    reset       = rst_val;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    cyc++;
    if (!reset) begin
      chk("rst_rom_req", rom_req, 1'b0);
      chk("rst_rom_addr", rom_addr, 32'h0);
      chk("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_fetch_error", fetch_error, 1'b0);
      q.delete();
      exp_fetch = RESET_PC;
      halted_m  = 1'b0;
      err_m     = 1'b0;
    end else begin
      avail = 0;
      foreach (q[i]) if (q[i].arrive <= cyc) avail++;
      exp_req = !halted_m && !redir && (q.size() < DEPTH);
      chk("rom_req", rom_req, exp_req);
      if (rom_req) chk("rom_addr", rom_addr, exp_fetch);
      chk("instr_valid", instr_valid, avail > 0);
      chk("fetch_error", fetch_error, err_m);
      if (avail > 0) begin
        chk("instr_pc", instr_pc, q[0].pc);
        chk("instr", instr, q[0].pc ^ ROM_KEY);
      end
      if (rom_req) req_pulses++;
      if (rom_req && first_req < 0) first_req = cyc;
      if (instr_valid && first_valid < 0) first_valid = cyc;
      // pop first, then issue, then flush: a pop in a redirect cycle completes
      if (avail > 0 && rdy) begin
        pop_log.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (exp_req) begin
        q.push_back('{exp_fetch, cyc + 2});
        exp_fetch = exp_fetch + 32'd4;
      end
      if (redir) begin
        q.delete();
        exp_fetch = {rpc[31:2], 2'b00};
        if (rpc[1:0] != 2'b00) begin
          halted_m = 1'b1;
          err_m    = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic        rr;
    logic        dd;
    logic [31:0] tt;

    // ---- reset values ----
    rst_val = 1'b0;
    repeat (3) tick(1'b1, 1'b0, 32'h0);

    // ---- release and stream ----
    rst_val = 1'b1;
    first_req = -1; first_valid = -1;
    pop_log.delete();
    repeat (12) tick(1'b1, 1'b0, 32'h0);
    chk("stream_first_req", first_req, 4);
    chk("stream_latency", first_valid - first_req, 2);
    for (int i = 0; i < 8; i++) chk("stream_pc", pop_log[i], i * 4);

    // ---- redirect with a pop in the same cycle ----
    pop_log.delete();
    tick(1'b1, 1'b1, 32'h0000_0100);
    chk("redir_pop_count", pop_log.size(), 1);
    tick(1'b1, 1'b0, 32'h0);
    chk("redir_addr_n1", rom_addr, 32'h0000_0100);
    chk("redir_valid_n1", instr_valid, 1'b0);
    tick(1'b1, 1'b0, 32'h0);
    chk("redir_valid_n2", instr_valid, 1'b0);
    tick(1'b1, 1'b0, 32'h0);
    chk("redir_valid_n3", instr_valid, 1'b1);
    chk("redir_pc_n3", instr_pc, 32'h0000_0100);
    repeat (4) tick(1'b1, 1'b0, 32'h0);
    chk("redir_seq0", pop_log[1], 32'h0000_0100);
    chk("redir_seq1", pop_log[2], 32'h0000_0104);

    // ---- address wrap ----
    pop_log.delete();
    tick(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (8) tick(1'b1, 1'b0, 32'h0);
    chk("wrap0", pop_log[0], 32'hFFFF_FFF8);
    chk("wrap1", pop_log[1], 32'hFFFF_FFFC);
    chk("wrap2", pop_log[2], 32'h0000_0000);
    chk("wrap3", pop_log[3], 32'h0000_0004);

    // ---- randomized ready and aligned redirects ----
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 3) != 0);
      dd = ($urandom_range(0, 19) == 0);
      tt = $urandom() & 32'hFFFF_FFFC;
      tick(rr, dd, tt);
    end

    // ---- backpressure from reset ----
    rst_val = 1'b0;
    tick(1'b0, 1'b0, 32'h0);
    rst_val = 1'b1;
    req_pulses = 0;
    pop_log.delete();
    repeat (10) tick(1'b0, 1'b0, 32'h0);
    chk("bp_req_pulses", req_pulses, 4);
    chk("bp_head_pc", instr_pc, 32'h0);
    chk("bp_head_instr", instr, ROM_KEY);
    repeat (8) tick(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) chk("bp_pc", pop_log[i], i * 4);

    // ---- misaligned target halts fetching ----
    tick(1'b1, 1'b1, 32'h0000_0102);
    tick(1'b1, 1'b0, 32'h0);
    chk("mis_err", fetch_error, 1'b1);
    req_pulses = 0;
    repeat (10) tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h0000_0200);
    repeat (9) tick(1'b1, 1'b0, 32'h0);
    chk("mis_req_pulses", req_pulses, 0);
    chk("mis_valid", instr_valid, 1'b0);
    chk("mis_err_sticky", fetch_error, 1'b1);
    rst_val = 1'b0;
    tick(1'b1, 1'b0, 32'h0);
    chk("mis_err_cleared", fetch_error, 1'b0);

    // ---- asynchronous reset mid-burst with three entries buffered ----
    rst_val = 1'b1;
    repeat (5) tick(1'b0, 1'b0, 32'h0);
    chk("pre_rst_valid", instr_valid, 1'b1);
    #2;
    rst_val = 1'b0;
    reset   = 1'b0;
    #1;
    chk("async_rom_req", rom_req, 1'b0);
    chk("async_rom_addr", rom_addr, 32'h0);
    chk("async_valid", instr_valid, 1'b0);
    chk("async_instr", instr, 32'h0);
    chk("async_instr_pc", instr_pc, 32'h0);
    chk("async_err", fetch_error, 1'b0);
    repeat (2) tick(1'b1, 1'b0, 32'h0);
    rst_val = 1'b1;
    first_req = -1; first_valid = -1;
    pop_log.delete();
    repeat (10) tick(1'b1, 1'b0, 32'h0);
    chk("restart_latency", first_valid - first_req, 2);
    for (int i = 0; i < 4; i++) chk("restart_pc", pop_log[i], RESET_PC + i * 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
